hazard_ctrl_mdu: RTL

//  Parametrised hazard/forwarding controller for the 5-stage MIPS pipeline (F/D/E/M/W).

---
 rtl/hazard_ctrl_mdu.sv | 135 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_mdu.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline with a
// multiply/divide busy tracker and a saturating stall-cycle counter.
module hazard_ctrl_mdu #(
    parameter int RA_W     = 5,
    parameter int T_W      = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [T_W-1:0]   tuse_rs,
    input  logic [T_W-1:0]   tuse_rt,
    input  logic [RA_W-1:0]  rs_d,
    input  logic [RA_W-1:0]  rt_d,
    input  logic [RA_W-1:0]  rs_e,
    input  logic [RA_W-1:0]  rt_e,
    input  logic [RA_W-1:0]  rt_m,
    input  logic [RA_W-1:0]  wr_e,
    input  logic [RA_W-1:0]  wr_m,
    input  logic [RA_W-1:0]  wr_w,
    input  logic             we_e,
    input  logic             we_m,
    input  logic             we_w,
    input  logic [T_W-1:0]   tnew_e,
    input  logic [T_W-1:0]   tnew_m,
    input  logic [T_W-1:0]   tnew_w,
    input  logic             mem_write_m,
    input  logic             md_use_d,
    input  logic             md_start_e,
    input  logic             md_div_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_e,
    output logic [1:0]       fwd_a_d,
    output logic [1:0]       fwd_b_d,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             fwd_m,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MD_W = $clog2(DIV_CYC + 1);

    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic             md_busy_q, md_busy_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             stall;

    // Register 0 is hardwired, so it can never be a real producer.
    function automatic logic match(input logic [RA_W-1:0] src,
                                   input logic [RA_W-1:0] wr,
                                   input logic            we);
        return (src != '0) && (src == wr) && we;
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src,
                                           input logic [RA_W-1:0] wrm,
                                           input logic            wem,
                                           input logic [T_W-1:0]  tnm,
                                           input logic [RA_W-1:0] wrw,
                                           input logic            wew,
                                           input logic [T_W-1:0]  tnw);
        logic [1:0] sel;
        sel = 2'b00;
        if (match(src, wrm, wem) && (tnm == '0))
            sel = 2'b01;
        else if (match(src, wrw, wew) && (tnw == '0))
            sel = 2'b10;
        return sel;
    endfunction

    // The nearest in-flight producer decides; a farther one is already stale.
    function automatic logic src_stall(input logic [RA_W-1:0] src,
                                       input logic [T_W-1:0]  tuse,
                                       input logic [RA_W-1:0] wre,
                                       input logic            wee,
                                       input logic [T_W-1:0]  tne,
                                       input logic [RA_W-1:0] wrm,
                                       input logic            wem,
                                       input logic [T_W-1:0]  tnm);
        logic s;
        s = 1'b0;
        if (match(src, wre, wee))
            s = (tuse < tne);
        else if (match(src, wrm, wem))
            s = (tuse < tnm);
        return s;
    endfunction

    always_comb begin
        stall = src_stall(rs_d, tuse_rs, wr_e, we_e, tnew_e, wr_m, we_m, tnew_m)
              | src_stall(rt_d, tuse_rt, wr_e, we_e, tnew_e, wr_m, we_m, tnew_m)
              | (md_use_d && (md_busy_q || md_start_e));
        stall_f = stall;
        stall_d = stall;
        flush_e = stall;
        fwd_a_d = fwd_sel(rs_d, wr_m, we_m, tnew_m, wr_w, we_w, tnew_w);
        fwd_b_d = fwd_sel(rt_d, wr_m, we_m, tnew_m, wr_w, we_w, tnew_w);
        fwd_a_e = fwd_sel(rs_e, wr_m, we_m, tnew_m, wr_w, we_w, tnew_w);
        fwd_b_e = fwd_sel(rt_e, wr_m, we_m, tnew_m, wr_w, we_w, tnew_w);
        fwd_m   = mem_write_m && match(rt_m, wr_w, we_w) && (tnew_w == '0);
    end

    // A start while the unit is still counting is dropped.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start_e && (md_cnt_q == '0))
            md_cnt_d = md_div_e ? MD_W'(DIV_CYC) : MD_W'(MULT_CYC);
        else if (md_cnt_q != '0)
            md_cnt_d = md_cnt_q - 1'b1;
        md_busy_d = (md_cnt_d != '0);

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt_q    <= '0;
            md_busy_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            md_busy_q   <= md_busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign md_busy   = md_busy_q;
    assign stall_cnt = stall_cnt_q;

endmodule
